// File: rtl/spi_pkg.sv
// Shared SPI link definitions for the initiator and the on-chip receiver.
// No logic: state encoding, byte width and mode-0 clock polarity/phase.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  // Mode 0: SCLK idles low, data captured on the leading (rising) edge.
  localparam logic SPI_MODE0_CPOL = 1'b0;
  localparam logic SPI_MODE0_CPHA = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SCLK_HI,
    SCLK_LO,
    WAIT,
    GAP
  } spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// Byte handshake plus SPI pins between the initiator and its user/slave side.
// Combinational bundle only; tx_valid/tx_ready is the backpressure point.
interface spi_master_if;
  import spi_pkg::*;

  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_last;
  logic                  tx_ready;
  logic [SPI_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  sclk;
  logic                  ssel;
  logic                  mosi;
  logic                  miso;

  modport master (
    input  tx_data, tx_valid, tx_last, miso,
    output tx_ready, rx_data, rx_valid, busy, sclk, ssel, mosi
  );

  modport slave (
    output tx_data, tx_valid, tx_last, miso,
    input  tx_ready, rx_data, rx_valid, busy, sclk, ssel, mosi
  );

endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: reloads to CLK_DIV-1 on i_load, o_tick when expired.
// Zero-latency tick (combinational from count); no backpressure.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: bytes shifted MSB-first, SSEL held across a frame; rx_valid 1+17H clk after accept.
// tx_ready only in IDLE/WAIT; tx_valid elsewhere is ignored, WAIT holds the frame open indefinitely.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_master_if.master  io_spi
);

  localparam int BIT_W = $clog2(SPI_BYTE_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SPI_BYTE_W - 1);
  localparam spi_state_t CAPTURE_ST = SPI_MODE0_CPHA ? SCLK_LO : SCLK_HI;
  localparam spi_state_t LAUNCH_ST  = SPI_MODE0_CPHA ? SCLK_HI : SCLK_LO;

  spi_state_t            r_state;
  spi_state_t            w_state_nxt;
  logic [SPI_BYTE_W-1:0] r_tx_shift;
  logic [SPI_BYTE_W-1:0] r_rx_shift;
  logic [SPI_BYTE_W-1:0] r_rx_data;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_last;
  logic                  r_mosi;
  logic                  r_sclk;
  logic                  r_ssel;
  logic                  r_rx_valid;
  logic                  w_tick;
  logic                  w_load;
  logic                  w_tx_ready;
  logic                  w_accept;
  logic                  w_last_bit;
  logic                  w_byte_done;

  assign w_tx_ready  = (r_state == IDLE) || (r_state == WAIT);
  assign w_accept    = io_spi.tx_valid && w_tx_ready;
  assign w_last_bit  = (r_bit_cnt == LAST_BIT);
  assign w_byte_done = (r_state == SCLK_LO) && w_tick && w_last_bit;
  assign w_load      = (w_state_nxt != r_state);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = LEAD;
      LEAD:    if (w_tick)   w_state_nxt = SCLK_HI;
      SCLK_HI: if (w_tick)   w_state_nxt = SCLK_LO;
      SCLK_LO: begin
        if (w_tick) begin
          if (!w_last_bit) w_state_nxt = SCLK_HI;
          else if (r_last) w_state_nxt = GAP;
          else             w_state_nxt = WAIT;
        end
      end
      WAIT:    if (w_accept) w_state_nxt = LEAD;
      GAP:     if (w_tick)   w_state_nxt = IDLE;
      default:               w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_last     <= 1'b0;
      r_mosi     <= 1'b0;
      r_sclk     <= SPI_MODE0_CPOL;
      r_ssel     <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tx_shift <= io_spi.tx_data;
        r_last     <= io_spi.tx_last;
        r_bit_cnt  <= '0;
        r_mosi     <= io_spi.tx_data[SPI_BYTE_W-1];
      end else if (r_state != LAUNCH_ST && w_state_nxt == LAUNCH_ST && !w_last_bit) begin
        r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
        r_mosi     <= r_tx_shift[SPI_BYTE_W-2];
      end

      // Bit counter wraps 7 -> 0 on the final SCLK_LO exit.
      if (!w_accept && r_state == SCLK_LO && w_tick) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (r_state != CAPTURE_ST && w_state_nxt == CAPTURE_ST) begin
        r_rx_shift <= {r_rx_shift[SPI_BYTE_W-2:0], io_spi.miso};
      end

      r_rx_valid <= w_byte_done;
      if (w_byte_done) begin
        r_rx_data <= r_rx_shift;
      end

      r_sclk <= (w_state_nxt == SCLK_HI) ? ~SPI_MODE0_CPOL : SPI_MODE0_CPOL;
      r_ssel <= (w_state_nxt inside {LEAD, SCLK_HI, SCLK_LO, WAIT});
    end
  end

  assign io_spi.tx_ready = w_tx_ready;
  assign io_spi.rx_data  = r_rx_data;
  assign io_spi.rx_valid = r_rx_valid;
  assign io_spi.busy     = (r_state != IDLE);
  assign io_spi.sclk     = r_sclk;
  assign io_spi.ssel     = r_ssel;
  assign io_spi.mosi     = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: H=2 and H=1 instances, loopback or shift-register slave on MISO.
// Expected rx bytes are queued at accept time and popped when rx_valid pulses.
module tb_spi_master;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if if2();
  spi_master_if if1();

  spi_master #(.CLK_DIV(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .io_spi(if2.master));
  spi_master #(.CLK_DIV(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io_spi(if1.master));

  logic       sel = 1'b0;   // 1 observes/drives the CLK_DIV=1 instance
  logic       loop = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic [7:0] slv_byte = 8'h00;
  logic [2:0] slv_idx = 3'd0;
  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;

  assign if2.tx_data  = tx_data;
  assign if1.tx_data  = tx_data;
  assign if2.tx_valid = tx_valid & ~sel;
  assign if1.tx_valid = tx_valid & sel;
  assign if2.tx_last  = tx_last;
  assign if1.tx_last  = tx_last;
  assign if2.miso     = loop ? if2.mosi : slv_byte[3'd7 - slv_idx];
  assign if1.miso     = if1.mosi;

  // Slave model: next bit presented on each SCLK fall, index cleared when SSEL drops.
  always @(negedge if2.sclk or negedge if2.ssel) begin
    if (!if2.ssel) slv_idx <= 3'd0;
    else           slv_idx <= slv_idx + 3'd1;
  end

  wire       w_sclk     = sel ? if1.sclk     : if2.sclk;
  wire       w_ssel     = sel ? if1.ssel     : if2.ssel;
  wire       w_mosi     = sel ? if1.mosi     : if2.mosi;
  wire       w_busy     = sel ? if1.busy     : if2.busy;
  wire       w_tx_ready = sel ? if1.tx_ready : if2.tx_ready;
  wire       w_rx_valid = sel ? if1.rx_valid : if2.rx_valid;
  wire [7:0] w_rx_data  = sel ? if1.rx_data  : if2.rx_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_tests++;
      if ({w_sclk, w_ssel, w_mosi, w_rx_valid, w_busy, w_tx_ready} !== 6'b000001) begin
        n_fail++;
        $display("FAIL reset_pins dut%0d: got %b want 000001", s,
                 {w_sclk, w_ssel, w_mosi, w_rx_valid, w_busy, w_tx_ready});
      end
      n_tests++;
      if (w_rx_data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_rx_data dut%0d: got %h want 00", s, w_rx_data);
      end
    end
    sel = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_single(input logic s, input int h, input logic [7:0] b,
                             input logic [7:0] exp_rx, input logic use_loop);
    int ssel_err = 0;
    int ready_err = 0;
    int rise_n = 0;
    int rise_err = 0;
    int rxv_n = 0;
    int rxv_cyc = -1;
    logic prev = 1'b0;
    logic [7:0] e;
    sel = s;
    loop = use_loop;
    #1;
    n_tests++;
    if (w_tx_ready !== 1'b1 || w_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle %h: ready=%b busy=%b want 1 0", b, w_tx_ready, w_busy);
    end
    tx_data = b;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    exp_q.push_back(exp_rx);
    tick();
    tx_valid = 1'b0;
    tx_data = 8'h00;
    for (int c = 1; c <= 18 * h + 3; c++) begin
      if (w_ssel !== (c <= 17 * h)) ssel_err++;
      if (w_tx_ready !== (c >= 18 * h + 1)) ready_err++;
      if (w_sclk === 1'b1 && prev === 1'b0) begin
        if (c != 1 + h + 2 * h * rise_n) rise_err++;
        rise_n++;
      end
      prev = w_sclk;
      if (w_rx_valid === 1'b1) begin
        rxv_n++;
        rxv_cyc = c;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL single_rx_unexpected: got %h want none", w_rx_data);
        end else begin
          e = exp_q.pop_front();
          if (w_rx_data !== e) begin
            n_fail++;
            $display("FAIL single_rx_data: got %h want %h", w_rx_data, e);
          end
        end
      end
      tick();
    end
    n_tests++;
    if (ssel_err != 0) begin
      n_fail++;
      $display("FAIL single_ssel %h: %0d bad cycles want 0 (high 1..%0d)", b, ssel_err, 17 * h);
    end
    n_tests++;
    if (ready_err != 0) begin
      n_fail++;
      $display("FAIL single_tx_ready %h: %0d bad cycles want 0 (return at %0d)", b, ready_err, 18 * h + 1);
    end
    n_tests++;
    if (rise_n != 8 || rise_err != 0) begin
      n_fail++;
      $display("FAIL single_sclk %h: rises=%0d misplaced=%0d want 8 0", b, rise_n, rise_err);
    end
    n_tests++;
    if (rxv_n != 1 || rxv_cyc != 1 + 17 * h) begin
      n_fail++;
      $display("FAIL single_rx_valid %h: count=%0d cycle=%0d want 1 %0d", b, rxv_n, rxv_cyc, 1 + 17 * h);
    end
    exp_q.delete();
    loop = 1'b1;
    sel = 1'b0;
  endtask

  task automatic test_frame();
    int rx_cnt = 0;
    int rises = 0;
    int ssel_err = 0;
    int wait_err = 0;
    int wait_cyc = 0;
    int last_fall = 0;
    int gap = -1;
    int hold = 0;
    int idx = 0;
    logic prev = 1'b0;
    logic done = 1'b0;
    logic acc;
    logic [7:0] e;
    sel = 1'b0;
    loop = 1'b1;
    tx_data = 8'h01;
    tx_last = 1'b0;
    tx_valid = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      acc = tx_valid && w_tx_ready;
      if (acc) exp_q.push_back(tx_data);
      tick();
      if (acc) begin
        idx++;
        if (idx == 1) tx_data = 8'h80;
        else          tx_valid = 1'b0;
      end
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          tx_data = 8'hFF;
          tx_last = 1'b1;
          tx_valid = 1'b1;
        end
      end
      if (w_rx_valid === 1'b1) begin
        rx_cnt++;
        if (rx_cnt == 2) hold = 10;
        n_tests++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (w_rx_data !== e) begin
          n_fail++;
          $display("FAIL frame_rx_data #%0d: got %h want %h", rx_cnt, w_rx_data, e);
        end
      end
      if (w_ssel !== (rx_cnt < 3)) ssel_err++;
      if (w_tx_ready === 1'b1 && w_busy === 1'b1) begin
        wait_cyc++;
        if (w_sclk !== 1'b0 || w_ssel !== 1'b1) wait_err++;
      end
      if (w_sclk === 1'b1 && prev === 1'b0) begin
        rises++;
        if (rx_cnt == 1 && gap < 0) gap = c + 1 - last_fall;
      end
      if (w_sclk === 1'b0 && prev === 1'b1) last_fall = c + 1;
      prev = w_sclk;
      if (rx_cnt == 3 && w_tx_ready === 1'b1) done = 1'b1;
    end
    tx_valid = 1'b0;
    tx_last = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL frame_timeout: rx_valid count %0d want 3 within 400 cycles", rx_cnt);
    end
    n_tests++;
    if (ssel_err != 0) begin
      n_fail++;
      $display("FAIL frame_ssel: %0d bad cycles want 0", ssel_err);
    end
    n_tests++;
    if (wait_err != 0 || wait_cyc < 11) begin
      n_fail++;
      $display("FAIL frame_wait: bad=%0d cycles=%0d want 0 >=11", wait_err, wait_cyc);
    end
    n_tests++;
    if (rises != 24) begin
      n_fail++;
      $display("FAIL frame_sclk_rises: got %0d want 24", rises);
    end
    n_tests++;
    if (gap != 5) begin
      n_fail++;
      $display("FAIL frame_b2b_gap: got %0d want 5", gap);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_scoreboard: %0d bytes left want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int rxv_err = 0;
    int busy_err = 0;
    sel = 1'b0;
    loop = 1'b1;
    tx_data = 8'hFF;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int c = 1; c < 12; c++) tick();
    n_tests++;
    if ({w_sclk, w_ssel, w_mosi} !== 3'b111) begin
      n_fail++;
      $display("FAIL mid_pre_reset: sclk/ssel/mosi got %b want 111", {w_sclk, w_ssel, w_mosi});
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({w_sclk, w_ssel, w_mosi, w_rx_valid, w_busy} !== 5'b00000) begin
      n_fail++;
      $display("FAIL mid_reset_pins: got %b want 00000", {w_sclk, w_ssel, w_mosi, w_rx_valid, w_busy});
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (w_rx_valid !== 1'b0) rxv_err++;
      if (w_busy !== 1'b0) busy_err++;
    end
    n_tests++;
    if (rxv_err != 0 || busy_err != 0) begin
      n_fail++;
      $display("FAIL mid_after_reset: rx_valid=%0d busy=%0d cycles want 0 0", rxv_err, busy_err);
    end
    test_single(1'b0, 2, 8'h96, 8'h96, 1'b1);
  endtask

  task automatic test_ignore();
    int rxv_n = 0;
    int busy_err = 0;
    logic pulsed = 1'b0;
    logic [7:0] e;
    sel = 1'b0;
    loop = 1'b1;
    tx_data = 8'h0F;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    exp_q.push_back(8'h0F);
    tick();
    tx_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (pulsed) tx_valid = 1'b0;
      if (w_sclk === 1'b1 && !pulsed) begin
        pulsed = 1'b1;
        n_tests++;
        if (w_tx_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_ready_hi: got %b want 0", w_tx_ready);
        end
        tx_data = 8'h55;
        tx_last = 1'b0;
        tx_valid = 1'b1;
      end
      if (w_rx_valid === 1'b1) begin
        rxv_n++;
        n_tests++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (w_rx_data !== e) begin
          n_fail++;
          $display("FAIL ignore_rx_data: got %h want %h", w_rx_data, e);
        end
      end
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      if (w_busy !== 1'b0) busy_err++;
      tick();
    end
    n_tests++;
    if (rxv_n != 1 || busy_err != 0 || !pulsed) begin
      n_fail++;
      $display("FAIL ignore_single_byte: rx=%0d busy_after=%0d pulsed=%b want 1 0 1", rxv_n, busy_err, pulsed);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 2, 8'hA5, 8'hA5, 1'b1);
    test_frame();
    slv_byte = 8'h3C;
    test_single(1'b0, 2, 8'h00, 8'h3C, 1'b0);
    test_reset_mid();
    test_ignore();
    test_single(1'b1, 1, 8'hC3, 8'hC3, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Byte-oriented SPI initiator for the demoscene design, running on the system clock and driving SCLK/SSEL/MOSI toward the on-chip SPI receiver. It is the transmitting end of the SPI link. It accepts bytes over a valid/ready handshake, shifts them out MSB-first with SSEL held active-high across a multi-byte frame, and returns the byte simultaneously shifted in on MISO.

## Interface
- CLK_DIV, 4, SCLK half-period in clk cycles (H); legal range 1..255
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_last  in  1  qualifies tx_data: final byte of frame; SSEL drops after it
- tx_ready  out  1  byte accepted on clk edge where tx_valid && tx_ready
- rx_data  out  8  byte captured from MISO; held until next capture
- rx_valid  out  1  one-cycle pulse, rx_data updated
- busy  out  1  high whenever state is not IDLE
- SCLK  out  1  serial clock, idle low (mode 0)
- SSEL  out  1  slave select, active high, idle low
- MOSI  out  1  serial data out, MSB first
- MISO  in  1  serial data in

## Operation
- States: IDLE, LEAD, SCLK_HI, SCLK_LO, WAIT, GAP.
- Reset values: SCLK=0, SSEL=0, MOSI=0, rx_data=0x00, rx_valid=0, busy=0, state IDLE.
- tx_ready = (state==IDLE || state==WAIT); combinational from state only. tx_valid in any other state is ignored.
- IDLE: on accept, latch tx_data into tx_shift, latch tx_last, bit count=0 -> LEAD. SSEL=1, MOSI=tx_data[7], SCLK=0.
- LEAD: H cycles with SCLK low (data setup) -> SCLK_HI.
- SCLK_HI: H cycles, SCLK=1. On the clk edge entering SCLK_HI, capture MISO into rx_shift LSB (shift left). Exit -> SCLK_LO.
- SCLK_LO: H cycles, SCLK=0. On entry, MOSI takes the next bit, unless this is the 8th bit. Exit:
  - bit count<7: bit count+1 -> SCLK_HI.
  - 8th bit: rx_data<=rx_shift, rx_valid=1 for one cycle. Go to GAP if the latched last flag is set, else WAIT.
- WAIT: SSEL=1, SCLK=0, MOSI holds. No timeout. On accept: latch the new byte, MOSI=bit7 -> LEAD.
- GAP: SSEL=0 for H cycles, so the receiver's bit/byte counters clear -> IDLE.
- Bit counter is 3 bits and wraps to 0 after bit 7. The half-period counter reloads on every state change.
- Asynchronous reset mid-frame: all outputs go to reset values immediately, SSEL drops, the partial byte is discarded, and rx_valid is not asserted.

## Timing
- All outputs registered; no glitches on SCLK/SSEL.
- Single byte, accept at cycle 0: SSEL rises at cycle 1. SCLK rising edges at cycles 1+H+2H·k, k=0..7. rx_valid and SSEL fall at cycle 1+17H. tx_ready returns at 1+18H.
- Multi-byte: inter-byte gap = H + WAIT cycles. With tx_valid held, the next byte's first SCLK rise is 2H+1 cycles after the previous byte's last SCLK fall.
- rx_valid and the WAIT state's tx_ready occur in the same cycle. A byte may be accepted in that cycle.
- MISO is sampled on the SCLK rising edge, H cycles after the receiver's falling-edge update; no synchroniser required.

## Structure
- Package spi_pkg: state enum (spi_state_t), SPI_BYTE_W=8, SPI_MODE0 constants; shared with the receiver.
- Sub-module spi_clk_div: half-period counter with load/tick, width $clog2(CLK_DIV+1).
- Top: FSM, tx/rx shift registers, bit counter.

## Test plan
- CLK_DIV=2, MISO tied to MOSI, send 0xA5 with tx_last=1 at cycle 0 -> SSEL high cycles 1..34, SCLK rises at 3,7,...,31, rx_valid at 35 with rx_data=0xA5, tx_ready at 37.
- Three-byte frame 0x01,0x80,0xFF, tx_valid dropped 10 cycles before byte 2 -> SSEL stays high throughout, WAIT holds SCLK=0, 24 SCLK rises, rx_valid ×3 with loopback values, SSEL falls only after 0xFF.
- MISO driven 0x3C by a bench slave model updating on SCLK fall, MOSI=0x00 -> rx_data=0x3C.
- Reset asserted at cycle 12 of a byte -> SCLK/SSEL/MOSI=0 in same cycle, no rx_valid; a new transfer after release completes correctly.
- CLK_DIV=1, single byte 0xC3 loopback -> SCLK period 2 clk, rx_valid at cycle 18, rx_data=0xC3.
- tx_valid pulsed with 0x55 during SCLK_HI of a byte -> ignored; only the original byte transmitted, tx_ready low.
